xpb_table_writer: RTL

//  Runtime generator for one xpb reduction lookup table. Given modulus N and base B = (2^k mod N),

---
 rtl/xpb_table_writer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/xpb_table_writer.sv
// Builds one xpb reduction table at runtime: entry[j] = (j*B) mod N, written in index order.
// Each entry is the previous one plus B. The add runs word-serially and is followed by one conditional subtract of N.
module xpb_table_writer #(
  parameter int MOD_LEN  = 1024,
  parameter int WORD_LEN = 64,
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MOD_LEN-1:0]  modulus,
  input  logic [MOD_LEN-1:0]  base,
  output logic                busy,
  output logic                done,
  output logic                wr_en,
  output logic [IDX_BITS-1:0] wr_addr,
  output logic [MOD_LEN-1:0]  wr_data,
  input  logic                wr_ready
);

  localparam int NUM_WORDS = MOD_LEN / WORD_LEN;
  localparam int WCW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int LW        = $clog2(MOD_LEN);
  localparam logic [WCW-1:0]      W_LAST   = WCW'(NUM_WORDS - 1);
  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ADD, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [MOD_LEN-1:0]  n_q, n_d;
  logic [MOD_LEN-1:0]  b_q, b_d;
  logic [MOD_LEN-1:0]  acc_q, acc_d;
  logic [MOD_LEN-1:0]  sum_q, sum_d;
  logic [MOD_LEN-1:0]  diff_q, diff_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [WCW-1:0]      w_q, w_d;
  logic                carry_q, carry_d;
  logic                borrow_q, borrow_d;

  logic [LW-1:0]       word_lsb;
  logic [WORD_LEN-1:0] a_w, bw_w, n_w;
  logic [WORD_LEN:0]   add_w, sub_w;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    b_d      = b_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    w_d      = w_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;

    // One slice of both the running sum and the trial subtraction per cycle.
    word_lsb = LW'(w_q) * LW'(WORD_LEN);
    a_w      = acc_q[word_lsb +: WORD_LEN];
    bw_w     = b_q[word_lsb +: WORD_LEN];
    n_w      = n_q[word_lsb +: WORD_LEN];
    add_w    = {1'b0, a_w} + {1'b0, bw_w} + {{WORD_LEN{1'b0}}, carry_q};
    sub_w    = {1'b0, add_w[WORD_LEN-1:0]} - {1'b0, n_w} - {{WORD_LEN{1'b0}}, borrow_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = modulus;
          b_d     = base;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + 1'b1;
            w_d      = '0;
            carry_d  = 1'b0;
            borrow_d = 1'b0;
            state_d  = S_ADD;
          end
        end
      end
      S_ADD: begin
        sum_d[word_lsb +: WORD_LEN]  = add_w[WORD_LEN-1:0];
        diff_d[word_lsb +: WORD_LEN] = sub_w[WORD_LEN-1:0];
        carry_d  = add_w[WORD_LEN];
        borrow_d = sub_w[WORD_LEN];
        w_d      = w_q + 1'b1;
        if (w_q == W_LAST) begin
          // sum >= N exactly when it overflowed or the subtraction did not borrow.
          acc_d   = (add_w[WORD_LEN] | ~sub_w[WORD_LEN]) ? diff_d : sum_d;
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      w_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      w_q      <= w_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign wr_en   = (state_q == S_WRITE);
  assign wr_addr = idx_q;
  assign wr_data = acc_q;

endmodule
